// File: rtl/store_data_packer.sv
// Store-path formatter: replicates a narrowed store onto its byte lanes, builds byte enables,
// flags misaligned/illegal stores, and queues results in a 2-entry output FIFO.
// Optional macro STORE_TRUNC_CHECK_EN adds the per-entry lossy flag and the lossy_count counter.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module store_data_packer #(
  parameter int WORD_LEN = `WORD_LEN,
  parameter int DEPTH    = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_size,
  input  logic [1:0]          in_addr_lo,
  input  logic [WORD_LEN-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_LEN-1:0] out_data,
  output logic [3:0]          out_byte_en,
  output logic                out_error,
  output logic                out_lossy,
  output logic [15:0]         lossy_count
);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef struct packed {
    logic [WORD_LEN-1:0] data;
    logic [3:0]          byte_en;
    logic                error;
  } entry_t;

  entry_t     fmt;
  entry_t     mem_q [DEPTH];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  assign in_ready  = (count_q != 2'(DEPTH));
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count_d   = count_q + {1'b0, push} - {1'b0, pop};

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    fmt = '0;
    case (size_e'(in_size))
      SZ_BYTE: begin
        fmt.data    = {4{in_data[7:0]}};
        fmt.byte_en = 4'b0001 << in_addr_lo;
      end
      SZ_HALF: begin
        if (!in_addr_lo[0]) begin
          fmt.data    = {2{in_data[15:0]}};
          fmt.byte_en = in_addr_lo[1] ? 4'b1100 : 4'b0011;
        end else begin
          fmt.error = 1'b1;
        end
      end
      SZ_WORD: begin
        if (in_addr_lo == 2'b00) begin
          fmt.data    = in_data;
          fmt.byte_en = 4'b1111;
        end else begin
          fmt.error = 1'b1;
        end
      end
      default: fmt.error = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= fmt;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign out_data    = out_valid ? mem_q[rd_ptr_q].data    : '0;
  assign out_byte_en = out_valid ? mem_q[rd_ptr_q].byte_en : 4'b0000;
  assign out_error   = out_valid ? mem_q[rd_ptr_q].error   : 1'b0;

`ifdef STORE_TRUNC_CHECK_EN
  logic        fmt_lossy;
  logic        lossy_q [DEPTH];
  logic [15:0] lossy_count_q;
  logic [23:0] upper_b;
  logic [15:0] upper_h;

  assign upper_b = in_data[31:8];
  assign upper_h = in_data[31:16];

  // Lossy when the discarded upper bits match neither zero- nor sign-extension of the kept part.
  always_comb begin
    fmt_lossy = 1'b0;
    if (!fmt.error) begin
      case (size_e'(in_size))
        SZ_BYTE: fmt_lossy = (upper_b != '0 && upper_b != '1) ||
                             (upper_b != {24{in_data[7]}} && upper_b != '0);
        SZ_HALF: fmt_lossy = (upper_h != '0 && upper_h != '1) ||
                             (upper_h != {16{in_data[15]}} && upper_h != '0);
        default: fmt_lossy = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lossy_count_q <= 16'd0;
      for (int i = 0; i < DEPTH; i++) lossy_q[i] <= 1'b0;
    end else begin
      if (push) lossy_q[wr_ptr_q] <= fmt_lossy;
      if (pop && lossy_q[rd_ptr_q] && lossy_count_q != 16'hFFFF)
        lossy_count_q <= lossy_count_q + 16'd1;
    end
  end

  assign out_lossy   = out_valid ? lossy_q[rd_ptr_q] : 1'b0;
  assign lossy_count = lossy_count_q;
`else
  assign out_lossy   = 1'b0;
  assign lossy_count = 16'd0;
`endif

endmodule

// File: tb/tb_store_data_packer.sv
// Directed bench for store_data_packer: a reference model fills an expected-entry queue on each
// accept, and the head is compared every cycle and retired on each output handshake.
`timescale 1ns/1ps

module tb_store_data_packer;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
    logic        err;
    logic        lossy;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_size;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_byte_en;
  logic        out_error;
  logic        out_lossy;
  logic [15:0] lossy_count;

  exp_t        q [$];
  logic [15:0] exp_lc = 16'd0;
  int          vectors = 0;
  int          miscompares = 0;

  store_data_packer dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_size     (in_size),
    .in_addr_lo  (in_addr_lo),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_byte_en (out_byte_en),
    .out_error   (out_error),
    .out_lossy   (out_lossy),
    .lossy_count (lossy_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  function automatic exp_t model(input logic [1:0] sz, input logic [1:0] a, input logic [31:0] d);
    exp_t e;
    e = '0;
    case (sz)
      2'b00: begin
        e.data = {d[7:0], d[7:0], d[7:0], d[7:0]};
        case (a)
          2'd0: e.be = 4'b0001;
          2'd1: e.be = 4'b0010;
          2'd2: e.be = 4'b0100;
          default: e.be = 4'b1000;
        endcase
        e.lossy = !(d == {{24{d[7]}}, d[7:0]} || d == {24'h0, d[7:0]});
      end
      2'b01: begin
        if (a == 2'd0 || a == 2'd2) begin
          e.data  = {d[15:0], d[15:0]};
          e.be    = (a == 2'd2) ? 4'b1100 : 4'b0011;
          e.lossy = !(d == {{16{d[15]}}, d[15:0]} || d == {16'h0, d[15:0]});
        end else begin
          e.err = 1'b1;
        end
      end
      2'b10: begin
        if (a == 2'd0) begin
          e.data = d;
          e.be   = 4'b1111;
        end else begin
          e.err = 1'b1;
        end
      end
      default: e.err = 1'b1;
    endcase
`ifndef STORE_TRUNC_CHECK_EN
    e.lossy = 1'b0;
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive, sample mid-cycle against the scoreboard, update it, advance.
  task automatic step(input logic v, input logic [1:0] sz, input logic [1:0] a,
                      input logic [31:0] d, input logic ordy);
    exp_t head;
    logic acc, pop;
    in_valid = v; in_size = sz; in_addr_lo = a; in_data = d; out_ready = ordy;
    #1;
    head = (q.size() != 0) ? q[0] : '0;
    check("in_ready",    32'(in_ready),    32'(q.size() < 2));
    check("out_valid",   32'(out_valid),   32'(q.size() != 0));
    check("out_data",    out_data,         head.data);
    check("out_byte_en", 32'(out_byte_en), 32'(head.be));
    check("out_error",   32'(out_error),   32'(head.err));
    check("out_lossy",   32'(out_lossy),   32'(head.lossy));
    check("lossy_count", 32'(lossy_count), 32'(exp_lc));
    acc = v && in_ready;
    pop = out_valid && ordy;
    if (pop && q.size() != 0) begin
      if (q[0].lossy && exp_lc != 16'hFFFF) exp_lc = exp_lc + 16'd1;
      void'(q.pop_front());
    end
    if (acc) q.push_back(model(sz, a, d));
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 2'b00, 2'b00, 32'h0, ordy);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_size = 2'b00; in_addr_lo = 2'b00;
    in_data = 32'h0; out_ready = 1'b0;
    #1;
    check("rst_in_ready",    32'(in_ready),    32'd1);
    check("rst_out_valid",   32'(out_valid),   32'd0);
    check("rst_out_data",    out_data,         32'd0);
    check("rst_out_byte_en", 32'(out_byte_en), 32'd0);
    check("rst_out_error",   32'(out_error),   32'd0);
    check("rst_out_lossy",   32'(out_lossy),   32'd0);
    check("rst_lossy_count", 32'(lossy_count), 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;

    // Byte replication onto all lanes, enable on lane 2.
    step(1'b1, 2'b00, 2'd2, 32'h1234_56AB, 1'b1);
    idle(1'b1);
    // Halfwords: sign-extended upper bits (not lossy), then non-extension upper bits (lossy).
    step(1'b1, 2'b01, 2'd2, 32'hFFFF_8001, 1'b1);
    step(1'b1, 2'b01, 2'd2, 32'h0001_8001, 1'b1);
    step(1'b1, 2'b00, 2'd1, 32'hFFFF_FF7F, 1'b1);
    step(1'b1, 2'b01, 2'd0, 32'h0000_7FFF, 1'b1);
    idle(1'b1);
    idle(1'b1);
    // Error entries: misaligned word, illegal size, misaligned half.
    step(1'b1, 2'b10, 2'd1, 32'hDEAD_BEEF, 1'b1);
    step(1'b1, 2'b11, 2'd0, 32'hCAFE_F00D, 1'b1);
    step(1'b1, 2'b01, 2'd3, 32'h0000_1234, 1'b1);
    step(1'b1, 2'b10, 2'd0, 32'h8765_4321, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Back-pressure: A, B fill the buffer; C is refused until a slot frees.
    step(1'b1, 2'b10, 2'd0, 32'hAAAA_0001, 1'b0);
    step(1'b1, 2'b10, 2'd0, 32'hBBBB_0002, 1'b0);
    step(1'b1, 2'b10, 2'd0, 32'hCCCC_0003, 1'b0);
    step(1'b1, 2'b10, 2'd0, 32'hCCCC_0003, 1'b0);
    step(1'b1, 2'b10, 2'd0, 32'hCCCC_0003, 1'b1);
    step(1'b1, 2'b10, 2'd0, 32'hCCCC_0003, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Streaming: one store per cycle, occupancy stays at most 1.
    for (int i = 0; i < 8; i++)
      step(1'b1, 2'(i % 3), 2'd0, 32'h1000_0000 + 32'(i) * 32'h0101_0111, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Randomised mix of sizes, addresses and back-pressure.
    for (int i = 0; i < 40; i++)
      step(1'(($urandom % 4) != 0), 2'($urandom), 2'($urandom), $urandom, 1'($urandom));
    for (int i = 0; i < 6 && q.size() != 0; i++) idle(1'b1);
    check("drained", 32'(q.size()), 32'd0);

    // Lossy entry then two buffered entries, then asynchronous reset mid-cycle.
    step(1'b1, 2'b00, 2'd0, 32'h0000_1280, 1'b1);
    idle(1'b1);
    step(1'b1, 2'b10, 2'd0, 32'h1111_1111, 1'b0);
    step(1'b1, 2'b10, 2'd0, 32'h2222_2222, 1'b0);
    in_valid = 1'b1; in_size = 2'b10; in_addr_lo = 2'd0; in_data = 32'h3333_3333; out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_out_valid",   32'(out_valid),   32'd0);
    check("async_in_ready",    32'(in_ready),    32'd1);
    check("async_lossy_count", 32'(lossy_count), 32'd0);
    check("async_out_data",    out_data,         32'd0);
    q.delete();
    exp_lc = 16'd0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    idle(1'b1);
    step(1'b1, 2'b01, 2'd0, 32'h0000_BEEF, 1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
